// File: rtl/taxi_sync_signal_filt.sv
// Multi-channel CDC synchronizer followed by a per-channel stability filter.
// Each channel emits registered rise/fall pulses when its filtered level changes.
module taxi_sync_signal_filt #(
  parameter int               WIDTH    = 1,
  parameter int               N        = 2,
  parameter int               FILT_CNT = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CNT - 1);

  if (N < 2) begin : g_bad_n
    $error("taxi_sync_signal_filt: N must be at least 2");
  end
  if (FILT_CNT < 1) begin : g_bad_filt
    $error("taxi_sync_signal_filt: FILT_CNT must be at least 1");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    // Plain flop chain; keep it out of shift-register primitives so each
    // stage gets its own flip-flop for metastability settling.
    (* srl_style = "register" *) logic [N-1:0] sync_reg;
    logic          s;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          out_reg, out_next;
    logic          rise_reg, fall_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_reg <= {N{RST_VAL[gi]}};
      end else begin
        sync_reg <= {sync_reg[N-2:0], in[gi]};
      end
    end

    assign s = sync_reg[N-1];

    // A change is committed only after s has differed from out for
    // FILT_CNT consecutive edges; any return to out discards progress.
    always_comb begin
      cnt_next = cnt_reg;
      out_next = out_reg;
      if (s == out_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_MAX) begin
        out_next = s;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg  <= '0;
        out_reg  <= RST_VAL[gi];
        rise_reg <= 1'b0;
        fall_reg <= 1'b0;
      end else begin
        cnt_reg  <= cnt_next;
        out_reg  <= out_next;
        rise_reg <= out_next & ~out_reg;
        fall_reg <= ~out_next & out_reg;
      end
    end

    assign out[gi]  = out_reg;
    assign rise[gi] = rise_reg;
    assign fall[gi] = fall_reg;
  end

endmodule

// File: doc/taxi_sync_signal_filt.md
TAXI_SYNC_SIGNAL_FILT -- requirements
Module: taxi_sync_signal_filt

Interface
REQ-001 SHALL have parameter WIDTH, default 1, number of independent single-bit channels.
REQ-002 SHALL have parameter N, default 2, synchronizer depth in register stages; N < 2 SHALL fail elaboration.
REQ-003 SHALL have parameter FILT_CNT, default 4, consecutive stable cycles required before the output changes; FILT_CNT < 1 SHALL fail elaboration.
REQ-004 SHALL have parameter RST_VAL, default 0, WIDTH-bit reset value of all stages and the output.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port in, input, WIDTH, asynchronous raw signals.
REQ-008 SHALL have port out, output, WIDTH, synchronized and filtered level, registered.
REQ-009 SHALL have port rise, output, WIDTH, one-cycle pulse per channel on an out 0->1 transition, registered.
REQ-010 SHALL have port fall, output, WIDTH, one-cycle pulse per channel on an out 1->0 transition, registered.

Function
REQ-011 Each channel SHALL pass through an N-stage register chain. The chain SHALL be forced to flip-flops (srl_style "register") and SHALL contain no logic between stages. The last stage is called s.
REQ-012 Each channel SHALL have a saturating counter cnt of width $clog2(FILT_CNT+1), updated every edge as follows.
- If s == out, cnt <= 0.
- Else if cnt == FILT_CNT-1, then out <= s and cnt <= 0.
- Else cnt <= cnt+1.
REQ-013 A change on in held stable and first captured at edge k SHALL appear on out after edge k+N+FILT_CNT-1. With FILT_CNT=1 this is edge k+N.
REQ-014 Any excursion of s lasting fewer than FILT_CNT cycles SHALL leave out, rise and fall unchanged, and SHALL return cnt to 0.
REQ-015 rise[i] SHALL be 1 exactly in the cycle where out[i] first reads 1 after being 0. fall[i] SHALL follow the same rule for 1->0. Both SHALL be 0 in all other cycles.
REQ-016 rise[i] and fall[i] SHALL never be high together. Each transition SHALL produce exactly one pulse.
REQ-017 Channels SHALL be fully independent. Simultaneous transitions on any subset of channels SHALL each follow REQ-013..REQ-015 without interaction.
REQ-018 When s toggles back to equal out while cnt is nonzero, the pending change SHALL be discarded. A later change SHALL restart counting from 0.
REQ-019 All outputs SHALL be driven directly from registers, with no combinational path from in to any output.

Reset
REQ-020 While rst=1 at an edge, the following SHALL load:
- all chain stages <= RST_VAL
- out <= RST_VAL
- cnt <= 0
- rise <= 0, fall <= 0
REQ-021 Reset SHALL take priority over all other updates, including a count that would complete on the same edge.
REQ-022 Reset asserted mid-count SHALL abandon the pending change. After release, a full REQ-013 latency SHALL apply.
REQ-023 After reset release with in == RST_VAL, no rise or fall pulse SHALL occur.

Verification
All scenarios use WIDTH=4, N=2, FILT_CNT=4, RST_VAL=4'h0 unless noted.
REQ-024 Reset held 3 cycles with in=4'h0, then released for 20 cycles -> out=4'h0, rise=fall=4'h0 in every cycle.
REQ-025 in[0] 0->1 captured at edge k and held -> out[0]=1 after edge k+5; rise[0]=1 for that cycle only; fall stays 0.
REQ-026 in[1] driven high for 3 cycles, then low -> out[1]=0 throughout; no rise or fall on any channel.
REQ-027 in 4'h0->4'hF on one edge, held; later in[2]->0 -> all out bits go to 1 on the same cycle with rise=4'hF for one cycle; later fall=4'h4 for one cycle and out=4'hB.
REQ-028 in[3] high for 4 cycles, then rst=1 for 1 cycle with in[3] kept high -> out[3]=0 and no rise during or immediately after reset; out[3]=1 after edge r+5, where r is the first post-reset capture edge.
REQ-029 Instance with RST_VAL=4'hF and FILT_CNT=1: in=4'hF through reset, then in[0]->0 -> no pulses after release; out[0]=0 after edge k+2 with fall=4'h1 for one cycle.
